// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB arbitration types: arbiter state encoding and a one-hot to index helper.
package ahb_arbiter_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned HOLD_W      = 8;

    typedef enum logic {
        ST_PARK = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // OR-reduction encoder; result is only meaningful for a one-hot input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module ahb_rr_picker
    import ahb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MASTER_W    = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MASTER_W-1:0]    ptr,
    input  logic [NUM_MASTERS-1:0] excl,
    output logic [MASTER_W-1:0]    winner,
    output logic                   found
);

    // Walk ptr+1 .. ptr+NUM_MASTERS (ptr itself last) and keep the first hit.
    always_comb begin
        logic [31:0]         idx;
        logic [MASTER_W-1:0] sel;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = (32'(ptr) + i) % NUM_MASTERS;
            sel = MASTER_W'(idx);
            if (!found && req[sel] && !excl[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with lock support and a per-owner hold limit.
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned MASTER_W       = 2,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 8
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MASTER_W-1:0]    hmaster,
    output logic [MASTER_W-1:0]    hmaster_data,
    output logic                   hmastlock
);

    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_e             state_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [MASTER_W-1:0]    ptr_q;

    logic [NUM_MASTERS-1:0] excl_c;
    logic [MASTER_W-1:0]    win_c;
    logic                   found_c;
    logic                   owner_req_c;
    logic                   owner_lock_c;

    // The current owner never competes in its own handover search.
    always_comb begin
        excl_c       = '0;
        owner_req_c  = hbusreq[hmaster];
        owner_lock_c = hlock[hmaster];
        if (state_q == ST_OWN) begin
            excl_c = NUM_MASTERS'(1) << hmaster;
        end
    end

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MASTER_W    (MASTER_W)
    ) u_picker (
        .req    (hbusreq),
        .ptr    (ptr_q),
        .excl   (excl_c),
        .winner (win_c),
        .found  (found_c)
    );

    // Arbitration FSM; everything advances only on hready-high cycles, reset wins over a stall.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q      <= ST_PARK;
            hold_q       <= '0;
            ptr_q        <= DEF_IDX;
            hgrant       <= DEF_GRANT;
            hmaster      <= DEF_IDX;
            hmaster_data <= DEF_IDX;
            hmastlock    <= 1'b0;
        end else if (hready) begin
            hmaster_data <= hmaster;
            case (state_q)
                ST_PARK: begin
                    hmastlock <= 1'b0;
                    if (found_c) begin
                        state_q <= ST_OWN;
                        hold_q  <= '0;
                        ptr_q   <= win_c;
                        hgrant  <= NUM_MASTERS'(1) << win_c;
                        hmaster <= win_c;
                    end
                end
                ST_OWN: begin
                    if (owner_req_c && owner_lock_c) begin
                        hmastlock <= 1'b1;
                    end else if (owner_req_c) begin
                        hmastlock <= 1'b0;
                        if (hold_q < HOLD_LAST) begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end else begin
                            hold_q <= '0;
                            if (found_c) begin
                                ptr_q   <= win_c;
                                hgrant  <= NUM_MASTERS'(1) << win_c;
                                hmaster <= win_c;
                            end
                        end
                    end else begin
                        hmastlock <= 1'b0;
                        hold_q    <= '0;
                        if (found_c) begin
                            ptr_q   <= win_c;
                            hgrant  <= NUM_MASTERS'(1) << win_c;
                            hmaster <= win_c;
                        end else begin
                            state_q <= ST_PARK;
                            hgrant  <= DEF_GRANT;
                            hmaster <= DEF_IDX;
                        end
                    end
                end
                default: begin
                    state_q <= ST_PARK;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Round-robin bus arbiter for the AHB fabric. It takes per-master bus requests, issues one-hot hgrant to the master interfaces, and publishes the address-phase owner (hmaster) and data-phase owner (hmaster_data) so the decoder and the read/write data muxes can steer.
- Re-arbitration happens only on hready-high cycles.
- Locked transfers are honoured.
- A hold limit stops any one master from monopolising the bus.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
MASTER_W, 2, width of master index; must equal ceil(log2(NUM_MASTERS))
DEFAULT_MASTER, 0, master parked on the bus when no request is pending
MAX_HOLD, 8, maximum hready-high cycles an unlocked owner keeps the grant while others wait (2..255)

Ports:
hclk  in  1  bus clock; all logic on rising edge
hreset  in  1  synchronous, active-high reset
hbusreq  in  NUM_MASTERS  bus request, bit i from master i
hlock  in  NUM_MASTERS  locked-transfer request, bit i from master i; only meaningful with hbusreq[i]
hready  in  1  transfer-complete from the selected slave
hgrant  out  NUM_MASTERS  one-hot grant to masters
hmaster  out  MASTER_W  index of the current address-phase owner
hmaster_data  out  MASTER_W  index of the current data-phase owner
hmastlock  out  1  current owner holds a locked sequence

Behaviour:
- Reset (hreset=1 at a rising edge):
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = hmaster_data = DEFAULT_MASTER; hmastlock = 0.
  - Hold counter = 0; round-robin pointer = DEFAULT_MASTER; state = PARK.
  - Reset asserted mid-transfer aborts ownership in the same edge, with no handover delay.
- All outputs are registered. A request seen at edge k produces hgrant at edge k+1 at the earliest (1-cycle latency).
- hready=0: state, hgrant, hmaster, hmaster_data, hmastlock and hold counter all freeze. Requests arriving during this time are evaluated on the first hready=1 edge.
- hready=1: hmaster_data <= hmaster (previous address-phase owner enters data phase), then the FSM below is evaluated.
- FSM states:
  - PARK: default master granted, no active owner.
  - OWN: master hmaster owns the bus because it requested.
- PARK, hready=1:
  - No hbusreq bit set: stay in PARK.
  - Otherwise: grant the first requester searching from pointer+1 upward, wrapping modulo NUM_MASTERS. Go to OWN; hold counter = 0; pointer = winner.
- OWN, hready=1, owner o:
  - hbusreq[o]=1 and hlock[o]=1: keep grant; hmastlock=1; hold counter not incremented.
  - hbusreq[o]=1, unlocked, hold counter < MAX_HOLD-1: keep grant; counter+1; hmastlock=0.
  - hbusreq[o]=1, unlocked, counter = MAX_HOLD-1:
    - Another request pending: round-robin to the next requester (o excluded from the search); counter = 0.
    - No other request: keep o and reset the counter to 0.
  - hbusreq[o]=0:
    - Any other request pending: round-robin from o+1; counter = 0; hmastlock = 0.
    - No request pending: go to PARK; grant DEFAULT_MASTER; hmaster = DEFAULT_MASTER.
- Handover at one edge updates hgrant and hmaster together.
- Invariants:
  - hgrant is always exactly one-hot.
  - hmaster equals the index of the set hgrant bit.
  - The counter never exceeds MAX_HOLD-1.
- Simultaneous requests: the winner is decided only by the pointer order, never by index priority.
- hlock[i] without hbusreq[i] is ignored.

Decomposition:
- Shared package: state encoding (PARK, OWN) and a one-hot-to-index function. The package is reused by the decoder and data muxes.
- One natural sub-module: ahb_rr_picker, a combinational rotate/priority-encode.
  - Inputs: request vector, pointer, exclude mask.
  - Outputs: winner index, found flag.

Test Plan:
- Reset with hbusreq=4'b0000, hready=1 -> hgrant=4'b0001, hmaster=0, hmaster_data=0, hmastlock=0; stays parked 5 cycles.
- From PARK, hbusreq=4'b1010 at edge k -> hgrant=4'b0010 at k+1. Drop master 1's request -> hgrant=4'b1000 next edge; hmaster_data follows hmaster one hready-cycle later.
- Masters 1 and 2 request continuously, unlocked, hready=1 -> grant alternates 1,2,1 every MAX_HOLD=8 cycles. Master 1 alone -> it keeps the grant indefinitely.
- Master 3 requests with hlock=1 for 20 cycles while 0 and 1 also request -> hgrant=4'b1000 and hmastlock=1 throughout. After hlock drops, it releases 8 cycles later to master 0.
- Hold hready=0 for 4 cycles during a requested handover -> hgrant, hmaster and hmaster_data frozen; the handover occurs on the first hready=1 edge.
- Assert hreset while master 2 owns in OWN with hready=0 -> next edge hgrant=4'b0001, hmaster=0, hmastlock=0.
